// File: rtl/as_lut_wr_arbiter_if.sv
// Purpose: bundles the requester-side and LUT-side write signals of the LUT write arbiter.
// Latency: none, this is wiring only.
// Backpressure: requesters hold req_wr_req until their ack; the LUT holds off via lut_wr_ack.
// Modports: master = the arbiter (drives the LUT write port and the acks back to requesters),
//           slave  = the environment (requesters, lookup engine and the LUT itself).
interface as_lut_wr_arbiter_if #(
    parameter int NUM_REQ           = 3,
    parameter int NUM_OUTPUT_QUEUES = 8,
    parameter int LUT_DEPTH_BITS    = 4
);
    // Requester side, packed per requester (requester i at slice i)
    logic [NUM_REQ-1:0]                   req_wr_req;
    logic [NUM_REQ*LUT_DEPTH_BITS-1:0]    req_wr_addr;
    logic [NUM_REQ*48-1:0]                req_wr_mac;
    logic [NUM_REQ*NUM_OUTPUT_QUEUES-1:0] req_wr_oq;
    logic [NUM_REQ-1:0]                   req_wr_protect;
    logic [NUM_REQ-1:0]                   req_wr_ack;
    logic [NUM_REQ-1:0]                   req_wr_err;

    // Lookup engine
    logic                                 lookup_active;

    // LUT write port
    logic                                 lut_wr_req;
    logic [LUT_DEPTH_BITS-1:0]            lut_wr_addr;
    logic [47:0]                          lut_wr_mac;
    logic [NUM_OUTPUT_QUEUES-1:0]         lut_wr_oq;
    logic                                 lut_wr_protect;
    logic                                 lut_wr_ack;

    logic                                 busy;

    modport master (
        input  req_wr_req, req_wr_addr, req_wr_mac, req_wr_oq, req_wr_protect,
        input  lookup_active, lut_wr_ack,
        output req_wr_ack, req_wr_err,
        output lut_wr_req, lut_wr_addr, lut_wr_mac, lut_wr_oq, lut_wr_protect,
        output busy
    );

    modport slave (
        output req_wr_req, req_wr_addr, req_wr_mac, req_wr_oq, req_wr_protect,
        output lookup_active, lut_wr_ack,
        input  req_wr_ack, req_wr_err,
        input  lut_wr_req, lut_wr_addr, lut_wr_mac, lut_wr_oq, lut_wr_protect,
        input  busy
    );
endinterface

// File: rtl/as_lut_wr_arbiter.sv
// Purpose: round-robin arbiter sharing the anti-spoof CAM LUT write port among NUM_REQ requesters.
// Latency: request sampled at edge t -> lut_wr_req from t+1; req_wr_ack one cycle after lut_wr_ack.
// Backpressure: no new grant while lookup_active or until the granted requester drops its request.
// Ports: clk, reset (sync, active-high); bus (master modport) carrying requester req/data/ack/err,
//        lookup_active, the LUT wr_* port with lut_wr_ack, and busy (high whenever not IDLE).
module as_lut_wr_arbiter #(
    parameter int NUM_REQ           = 3,
    parameter int NUM_OUTPUT_QUEUES = 8,
    parameter int LUT_DEPTH_BITS    = 4,
    parameter int TIMEOUT_CYCLES    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    as_lut_wr_arbiter_if.master   bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {IDLE, WAIT_ACK, RELEASE} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   gnt_q;       // requester owning the current write
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W:0]     cand;        // one extra bit so rr_ptr+i can wrap without overflow
    logic               grant_vld;
    logic [CNT_W-1:0]   cnt;
    logic               timeout_hit;
    logic               do_grant;
    logic               do_done;
    logic               do_err;
    logic [NUM_REQ-1:0] gnt_onehot;
    logic [IDX_W-1:0]   rr_ptr_nxt;

    // Round-robin search: first requester at or above rr_ptr, wrapping
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NUM_REQ))
                cand = cand - (IDX_W+1)'(NUM_REQ);
            if (!grant_vld && bus.req_wr_req[cand[IDX_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[IDX_W-1:0];
            end
        end
    end

    // The counter is 0 on the first WAIT_ACK edge, so reaching TIMEOUT_CYCLES-1 here means
    // lut_wr_req has been high for exactly TIMEOUT_CYCLES cycles once this edge drops it.
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign gnt_onehot  = NUM_REQ'(1) << gnt_q;
    assign rr_ptr_nxt  = (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + IDX_W'(1);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (grant_vld && !bus.lookup_active)  state_nxt = WAIT_ACK;
            WAIT_ACK: if (bus.lut_wr_ack || timeout_hit)    state_nxt = RELEASE;
            RELEASE:  if (!bus.req_wr_req[gnt_q])           state_nxt = IDLE;
            default:                                        state_nxt = IDLE;
        endcase
    end

    // Output / action decode; an ack on the timeout cycle wins over the error
    always_comb begin
        do_grant       = (state == IDLE) && grant_vld && !bus.lookup_active;
        do_done        = (state == WAIT_ACK) && (bus.lut_wr_ack || timeout_hit);
        do_err         = (state == WAIT_ACK) && !bus.lut_wr_ack && timeout_hit;
        bus.lut_wr_req = (state == WAIT_ACK);
        bus.busy       = (state != IDLE);
    end

    // Grant capture, timeout counter, ack/err pulses and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr             <= '0;
            gnt_q              <= '0;
            cnt                <= '0;
            bus.lut_wr_addr    <= '0;
            bus.lut_wr_mac     <= '0;
            bus.lut_wr_oq      <= '0;
            bus.lut_wr_protect <= 1'b0;
            bus.req_wr_ack     <= '0;
            bus.req_wr_err     <= '0;
        end else begin
            bus.req_wr_ack <= '0;
            bus.req_wr_err <= '0;
            if (do_grant) begin
                gnt_q              <= grant_idx;
                cnt                <= '0;
                bus.lut_wr_addr    <= bus.req_wr_addr[grant_idx*LUT_DEPTH_BITS +: LUT_DEPTH_BITS];
                bus.lut_wr_mac     <= bus.req_wr_mac[grant_idx*48 +: 48];
                bus.lut_wr_oq      <= bus.req_wr_oq[grant_idx*NUM_OUTPUT_QUEUES +: NUM_OUTPUT_QUEUES];
                bus.lut_wr_protect <= bus.req_wr_protect[grant_idx];
            end else if (state == WAIT_ACK && cnt != '1) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (do_done) begin
                bus.req_wr_ack <= gnt_onehot;
                bus.req_wr_err <= do_err ? gnt_onehot : '0;
                rr_ptr         <= rr_ptr_nxt;
            end
        end
    end
endmodule

// File: tb/tb_as_lut_wr_arbiter.sv
// Purpose: self-checking bench for as_lut_wr_arbiter with a scoreboard on LUT writes and acks.
// Latency: expectations are queued before stimulus; a negedge monitor pops them as outputs appear.
// Backpressure: a built-in LUT model acks after ack_delay cycles (0 = never ack).
module tb_as_lut_wr_arbiter;
    localparam int NR  = 3;
    localparam int NOQ = 8;
    localparam int LDB = 4;
    localparam int TO  = 8;

    typedef struct { int idx; int len; } wr_exp_t;              // len 0 = do not check length
    typedef struct { logic [NR-1:0] ack; logic [NR-1:0] err; } ack_exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    as_lut_wr_arbiter_if #(.NUM_REQ(NR), .NUM_OUTPUT_QUEUES(NOQ), .LUT_DEPTH_BITS(LDB)) bus();

    as_lut_wr_arbiter #(
        .NUM_REQ(NR), .NUM_OUTPUT_QUEUES(NOQ), .LUT_DEPTH_BITS(LDB), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    wr_exp_t  wr_q[$];
    ack_exp_t ack_q[$];
    int n_vec = 0;
    int n_err = 0;
    int ack_delay = 2;
    int lut_cyc = 0;

    function automatic logic [LDB-1:0] req_addr(input int i); return LDB'(5 + 3*i); endfunction
    function automatic logic [47:0] req_mac(input int i);
        return 48'h0011_2233_4455 + 48'(i) * 48'h0101_0101_0101;
    endfunction
    function automatic logic [NOQ-1:0] req_oq(input int i); return NOQ'(8'h11 << i); endfunction
    function automatic logic req_prot(input int i); return (i == 1); endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock step; also runs the LUT ack model and requester auto-drop after each ack
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.lut_wr_req) lut_cyc++;
        else                lut_cyc = 0;
        bus.lut_wr_ack = (ack_delay != 0) && (lut_cyc == ack_delay);
        bus.req_wr_req = bus.req_wr_req & ~bus.req_wr_ack;
    endtask

    task automatic push_wr(input int idx, input int len);
        wr_exp_t e;
        e.idx = idx; e.len = len;
        wr_q.push_back(e);
    endtask

    task automatic push_ack(input logic [NR-1:0] a, input logic [NR-1:0] e);
        ack_exp_t x;
        x.ack = a; x.err = e;
        ack_q.push_back(x);
    endtask

    task automatic wait_done(input int max, input string name);
        int n = 0;
        while ((bus.busy || bus.req_wr_req != 0 || ack_q.size() != 0) && n < max) begin
            tick();
            n++;
        end
        check(name, 64'(n < max), 64'd1);
        tick();
    endtask

    // Monitor / scoreboard
    logic    mon_prev = 1'b0;
    int      mon_hi   = 0;
    wr_exp_t mon_cur  = '{idx: -1, len: 0};
    initial begin
        ack_exp_t ae;
        forever begin
            @(negedge clk);
            if (bus.lut_wr_req && !mon_prev) begin
                if (wr_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_write: addr %0h, no write expected", bus.lut_wr_addr);
                    mon_cur.idx = -1; mon_cur.len = 0;
                end else begin
                    mon_cur = wr_q.pop_front();
                    check("wr_addr", 64'(bus.lut_wr_addr), 64'(req_addr(mon_cur.idx)));
                    check("wr_mac",  64'(bus.lut_wr_mac),  64'(req_mac(mon_cur.idx)));
                    check("wr_oq",   64'(bus.lut_wr_oq),   64'(req_oq(mon_cur.idx)));
                    check("wr_prot", 64'(bus.lut_wr_protect), 64'(req_prot(mon_cur.idx)));
                end
                mon_hi = 1;
            end else if (bus.lut_wr_req) begin
                mon_hi++;
            end else if (mon_prev && mon_cur.len != 0) begin
                check("wr_len", 64'(mon_hi), 64'(mon_cur.len));
            end
            if (bus.req_wr_ack != 0 || bus.req_wr_err != 0) begin
                if (ack_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_ack: ack %b err %b, none expected",
                             bus.req_wr_ack, bus.req_wr_err);
                end else begin
                    ae = ack_q.pop_front();
                    check("ack_vec", 64'(bus.req_wr_ack), 64'(ae.ack));
                    check("err_vec", 64'(bus.req_wr_err), 64'(ae.err));
                end
            end
            mon_prev = bus.lut_wr_req;
        end
    end

    initial begin
        bus.req_wr_req    = '0;
        bus.lookup_active = 1'b0;
        bus.lut_wr_ack    = 1'b0;
        for (int i = 0; i < NR; i++) begin
            bus.req_wr_addr[i*LDB +: LDB] = req_addr(i);
            bus.req_wr_mac[i*48 +: 48]    = req_mac(i);
            bus.req_wr_oq[i*NOQ +: NOQ]   = req_oq(i);
            bus.req_wr_protect[i]         = req_prot(i);
        end
        reset = 1'b1;
        repeat (3) tick();
        check("rst_lut_wr_req", 64'(bus.lut_wr_req), 64'd0);
        check("rst_busy",       64'(bus.busy),       64'd0);
        check("rst_ack",        64'(bus.req_wr_ack), 64'd0);
        check("rst_err",        64'(bus.req_wr_err), 64'd0);
        check("rst_addr",       64'(bus.lut_wr_addr), 64'd0);
        check("rst_mac",        64'(bus.lut_wr_mac), 64'd0);
        reset = 1'b0;
        tick();

        // 1: single write, LUT acks in the 2nd cycle of lut_wr_req
        ack_delay = 2;
        push_wr(0, 2);
        push_ack(3'b001, 3'b000);
        bus.req_wr_req = 3'b001;
        tick();
        check("t1_req_latency", 64'(bus.lut_wr_req), 64'd1);
        tick();
        tick();
        check("t1_ack_timing", 64'(bus.req_wr_ack), 64'b001);
        check("t1_req_dropped", 64'(bus.lut_wr_req), 64'd0);
        wait_done(50, "t1_done");

        // 2: all three request together from rr_ptr=0 -> order 0,1,2
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ack_delay = 3;
        for (int i = 0; i < NR; i++) begin
            push_wr(i, 3);
            push_ack(NR'(1) << i, '0);
        end
        bus.req_wr_req = 3'b111;
        wait_done(200, "t2_done");

        // 3: lookup_active blocks the grant
        ack_delay = 1;
        push_wr(1, 1);
        push_ack(3'b010, 3'b000);
        bus.lookup_active = 1'b1;
        bus.req_wr_req    = 3'b010;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t3_blocked", 64'(bus.lut_wr_req), 64'd0);
        end
        bus.lookup_active = 1'b0;
        tick();
        check("t3_release", 64'(bus.lut_wr_req), 64'd1);
        wait_done(50, "t3_done");

        // 4: LUT never acks -> timeout after TO cycles with ack+err
        ack_delay = 0;
        push_wr(2, TO);
        push_ack(3'b100, 3'b100);
        bus.req_wr_req = 3'b100;
        wait_done(100, "t4_done");

        // 5: ack on the timeout cycle wins, err stays 0
        ack_delay = TO;
        push_wr(0, TO);
        push_ack(3'b001, 3'b000);
        bus.req_wr_req = 3'b001;
        wait_done(100, "t5_done");

        // 6: reset while waiting for the LUT ack, then restart from requester 0
        ack_delay = 0;
        push_wr(1, 0);
        bus.req_wr_req = 3'b010;
        tick();
        tick();
        tick();
        check("t6_in_wait", 64'(bus.lut_wr_req), 64'd1);
        reset = 1'b1;
        bus.req_wr_req = 3'b000;
        tick();
        check("t6_req_dropped", 64'(bus.lut_wr_req), 64'd0);
        check("t6_busy",        64'(bus.busy),       64'd0);
        check("t6_no_ack",      64'(bus.req_wr_ack), 64'd0);
        reset = 1'b0;
        ack_delay = 1;
        push_wr(0, 1);
        push_ack(3'b001, 3'b000);
        push_wr(1, 1);
        push_ack(3'b010, 3'b000);
        bus.req_wr_req = 3'b011;
        wait_done(100, "t6_done");

        repeat (3) tick();
        check("wr_q_empty",  64'(wr_q.size()),  64'd0);
        check("ack_q_empty", 64'(ack_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
